alu_multicycle: RTL

//  Execution stage downstream of ALU control: consumes the 4-bit ALUOperation code and runs it on two
//  32-bit operands. Logic/arith/LUI ops finish in 1 cycle. SLL/SRL use an iterative 1-bit/cycle shifter
//  to save area. Start/done handshake lets the surrounding control stall the datapath while busy.

---
 rtl/alu_multicycle_pkg.sv | 23 ++
 rtl/alu_core_comb.sv | 29 ++
 rtl/alu_multicycle.sv | 94 +++++++++
 3 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared op-code and FSM-state definitions for ALU control and the multicycle execution stage.
package alu_multicycle_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_LUI     = 4'b0101;
    localparam logic [3:0] OP_SRL     = 4'b1110;
    localparam logic [3:0] OP_SLL     = 4'b1111;
    localparam logic [3:0] OP_ILLEGAL = 4'b1001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Single-cycle combinational ALU: logic, add/sub, LUI and unsupported-code detection.
module alu_core_comb
    import alu_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [DATA_WIDTH-1:0] core_result,
    output logic                  core_illegal
);

    // Shift codes land in the default arm; the iterative shifter in the top handles them.
    always_comb begin
        core_result  = '0;
        core_illegal = 1'b0;
        unique case (alu_op)
            OP_AND:  core_result = a_data & b_data;
            OP_OR:   core_result = a_data | b_data;
            OP_NOR:  core_result = ~(a_data | b_data);
            OP_ADD:  core_result = a_data + b_data;
            OP_SUB:  core_result = a_data - b_data;
            OP_LUI:  core_result = b_data << 16;
            default: core_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execution stage: one-cycle ALU ops plus a 1-bit/cycle iterative SLL/SRL with start/done handshake.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             alu_op,
    input  logic [DATA_WIDTH-1:0]  a_data,
    input  logic [DATA_WIDTH-1:0]  b_data,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
    output logic                   done,
    output logic                   busy,
    output logic                   illegal_op
);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   shift_left;
    logic [DATA_WIDTH-1:0]  core_result;
    logic                   core_illegal;
    logic [DATA_WIDTH-1:0]  shreg_next;

    alu_core_comb #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .alu_op       (alu_op),
        .a_data       (a_data),
        .b_data       (b_data),
        .core_result  (core_result),
        .core_illegal (core_illegal)
    );

    assign shreg_next = shift_left ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[DATA_WIDTH-1:1]};

    // zero is decoded from the result register only, so it never sees the inputs.
    assign zero = (result == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_shift(alu_op)) begin
                            if (shamt == '0) begin
                                result     <= b_data;
                                illegal_op <= 1'b0;
                                done       <= 1'b1;
                            end else begin
                                shreg      <= b_data;
                                cnt        <= shamt;
                                shift_left <= (alu_op == OP_SLL);
                                busy       <= 1'b1;
                                state      <= ST_SHIFT;
                            end
                        end else begin
                            result     <= core_result;
                            illegal_op <= core_illegal;
                            done       <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHAMT_WIDTH'(1)) begin
                        result     <= shreg_next;
                        illegal_op <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
